// File: rtl/mips_cpu_store_sequencer_if.sv
// Store-path bundle between the decode/execute datapath, the store sequencer and
// the word-write-only Harvard data memory.
interface mips_cpu_store_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [1:0]        store_type;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       mem_readdata;
  logic [ADDR_W-1:0] data_address;
  logic              data_read;
  logic              data_write;
  logic [31:0]       data_writedata;
  logic              stall;
  logic              done;
  logic              error;

  modport master (
    output start, store_type, addr, wdata, mem_readdata,
    input  data_address, data_read, data_write, data_writedata, stall, done, error
  );

  modport slave (
    input  start, store_type, addr, wdata, mem_readdata,
    output data_address, data_read, data_write, data_writedata, stall, done, error
  );
endinterface

// File: rtl/mips_cpu_store_sequencer.sv
// SB/SH/SW sequencer for a data memory that takes only whole-word writes.
// Sub-word stores are done as read-modify-write of the aligned word.
module mips_cpu_store_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  mips_cpu_store_sequencer_if.slave         bus
);

  localparam logic [1:0] ST_BYTE = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       wbuf_q, wbuf_d;

  logic [ADDR_W-1:0] data_address_s;
  logic              data_read_s;
  logic              data_write_s;
  logic [31:0]       data_writedata_s;
  logic              stall_s;
  logic              done_s;
  logic              error_s;

  // Little-endian lane insert of the store data into the word read back.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [31:0] src,
    input logic [1:0]  typ,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = word;
    case (typ)
      ST_BYTE: r[{off, 3'b000} +: 8]     = src[7:0];
      ST_HALF: r[{off[1], 4'b0000} +: 16] = src[15:0];
      default: r = word;
    endcase
    return r;
  endfunction

  // State and request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      type_q  <= 2'b00;
      wbuf_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    type_d           = type_q;
    wbuf_d           = wbuf_q;
    data_address_s   = '0;
    data_read_s      = 1'b0;
    data_write_s     = 1'b0;
    data_writedata_s = 32'd0;
    stall_s          = 1'b0;
    done_s           = 1'b0;
    error_s          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          type_d  = bus.store_type;
          case (bus.store_type)
            ST_WORD: state_d = (bus.addr[1:0] == 2'b00) ? S_WRITE : S_ERR;
            ST_BYTE: state_d = S_READ;
            ST_HALF: state_d = bus.addr[0] ? S_ERR : S_READ;
            default: state_d = S_ERR;
          endcase
          // A dropped request never freezes the pipeline.
          stall_s = (state_d != S_ERR);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        data_read_s    = 1'b1;
        data_address_s = {addr_q[ADDR_W-1:2], 2'b00};
        stall_s        = 1'b1;
        state_d        = S_MERGE;
      end
      S_MERGE: begin
        wbuf_d  = merge_lane(bus.mem_readdata, wdata_q, type_q, addr_q[1:0]);
        stall_s = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        data_write_s     = 1'b1;
        data_address_s   = {addr_q[ADDR_W-1:2], 2'b00};
        data_writedata_s = (type_q == ST_WORD) ? wdata_q : wbuf_q;
        done_s           = 1'b1;
        state_d          = S_IDLE;
      end
      S_ERR: begin
        error_s = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // stall in IDLE follows start combinationally, so it is forced low while reset is held.
  assign bus.data_address   = data_address_s;
  assign bus.data_read      = data_read_s;
  assign bus.data_write     = data_write_s;
  assign bus.data_writedata = data_writedata_s;
  assign bus.stall          = stall_s & reset;
  assign bus.done           = done_s;
  assign bus.error          = error_s;

endmodule
